instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache.sv | 110 +++++++++++
 tb/tb_instr_cache.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - host-loaded instruction cache with registered control-unit read port
module instr_cache #(
  parameter int DEPTH = 1024,
  parameter int IW    = 54
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_clear,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [IW-1:0] host_wr_data,
  input  logic          host_wr_last,
  input  logic          icache_rd_ctrl_en,
  input  logic [9:0]    icache_rd_ctrl_addr,
  output logic [IW-1:0] icache_rd_ctrl_data,
  output logic          finish_flag,
  output logic          prog_loaded,
  output logic [10:0]   prog_len,
  output logic          load_ovf
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_LOADING = 2'd1;
  localparam logic [1:0] S_LOADED  = 2'd2;

  // Highest writable slot; wr_ptr parks here once the array is full.
  localparam logic [9:0] LAST_PTR = 10'(DEPTH - 1);

  logic [1:0]    r_state;
  logic [9:0]    r_wr_ptr;
  logic [10:0]   r_prog_len;
  logic          r_load_ovf;
  logic [IW-1:0] r_rd_data;
  logic          r_finish;
  logic [IW-1:0] r_mem [DEPTH];

  logic          w_wr_ready;
  logic          w_wr_fire;
  logic          w_rd_hit;

  // Writes are only open until a program is fully loaded; clear and reset both
  // veto a write presented in the same cycle so memory stays untouched.
  assign w_wr_ready = (r_state != S_LOADED);
  assign w_wr_fire  = rst_n && host_wr_valid && w_wr_ready && !host_clear;

  // Reads return data only for a loaded program and an address inside it,
  // judged on the state and length as they stand before the edge.
  assign w_rd_hit   = (r_state == S_LOADED) && ({1'b0, icache_rd_ctrl_addr} < r_prog_len);

  assign host_wr_ready = w_wr_ready;
  assign prog_loaded   = (r_state == S_LOADED);
  assign prog_len      = r_prog_len;
  assign load_ovf      = r_load_ovf;
  assign icache_rd_ctrl_data = r_rd_data;
  assign finish_flag   = r_finish;

  // Load bookkeeping: state, write pointer, program length and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_wr_ptr   <= 10'd0;
      r_prog_len <= 11'd0;
      r_load_ovf <= 1'b0;
    end else if (host_clear) begin
      r_state    <= S_EMPTY;
      r_wr_ptr   <= 10'd0;
      r_prog_len <= 11'd0;
      r_load_ovf <= 1'b0;
    end else if (w_wr_fire) begin
      // At most DEPTH writes reach here before LOADED, so 11 bits never wrap.
      r_prog_len <= r_prog_len + 11'd1;
      if (r_wr_ptr != LAST_PTR) begin
        r_wr_ptr <= r_wr_ptr + 10'd1;
      end
      if (host_wr_last) begin
        r_state <= S_LOADED;
      end else if (r_wr_ptr == LAST_PTR) begin
        // Array filled without an end marker: close the load and flag it.
        r_state    <= S_LOADED;
        r_load_ovf <= 1'b1;
      end else begin
        r_state <= S_LOADING;
      end
    end
  end

  // Instruction storage; deliberately not reset so contents survive clear.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= host_wr_data;
    end
  end

  // Registered read port; outputs hold whenever no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_finish  <= 1'b1;
    end else if (icache_rd_ctrl_en) begin
      if (w_rd_hit) begin
        r_rd_data <= r_mem[icache_rd_ctrl_addr];
        r_finish  <= 1'b0;
      end else begin
        r_rd_data <= '0;
        r_finish  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - directed self-checking bench for instr_cache
module tb_instr_cache;

  logic        clk;
  logic        rst_n;
  logic        host_clear;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [53:0] host_wr_data;
  logic        host_wr_last;
  logic        icache_rd_ctrl_en;
  logic [9:0]  icache_rd_ctrl_addr;
  logic [53:0] icache_rd_ctrl_data;
  logic        finish_flag;
  logic        prog_loaded;
  logic [10:0] prog_len;
  logic        load_ovf;

  int n_checks;
  int n_errors;

  localparam logic [53:0] WA = 54'h0_1111_2222_3333;
  localparam logic [53:0] WB = 54'h2_AAAA_BBBB_CCCC;
  localparam logic [53:0] WC = 54'h3_DEAD_BEEF_0001;
  localparam logic [53:0] WX = 54'h1_0F0F_0F0F_0F0F;
  localparam logic [53:0] WY = 54'h2_F0F0_F0F0_F0F0;
  localparam logic [53:0] WK = 54'h0_CAFE_F00D_1234;
  localparam logic [53:0] WM0 = 54'h1_2345_6789_ABCD;
  localparam logic [53:0] WM1 = 54'h3_FEDC_BA98_7654;

  instr_cache #(.DEPTH(1024), .IW(54)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .host_clear          (host_clear),
    .host_wr_valid       (host_wr_valid),
    .host_wr_ready       (host_wr_ready),
    .host_wr_data        (host_wr_data),
    .host_wr_last        (host_wr_last),
    .icache_rd_ctrl_en   (icache_rd_ctrl_en),
    .icache_rd_ctrl_addr (icache_rd_ctrl_addr),
    .icache_rd_ctrl_data (icache_rd_ctrl_data),
    .finish_flag         (finish_flag),
    .prog_loaded         (prog_loaded),
    .prog_len            (prog_len),
    .load_ovf            (load_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [53:0] ovf_word(input int i);
    return {22'h2A5A5A, 32'(i)};
  endfunction

  task automatic write_word(input logic [53:0] d, input logic last);
    @(negedge clk);
    host_wr_valid = 1'b1;
    host_wr_data  = d;
    host_wr_last  = last;
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
  endtask

  task automatic read_addr(input logic [9:0] a);
    @(negedge clk);
    icache_rd_ctrl_en   = 1'b1;
    icache_rd_ctrl_addr = a;
    @(posedge clk);
    #1;
    icache_rd_ctrl_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    host_clear = 1'b1;
    @(posedge clk);
    #1;
    host_clear = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (prog_loaded !== 1'b0) begin n_errors++; $display("FAIL reset_loaded: got %b expected 0", prog_loaded); end
    n_checks++; if (prog_len !== 11'd0) begin n_errors++; $display("FAIL reset_len: got %0d expected 0", prog_len); end
    n_checks++; if (load_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", load_ovf); end
    n_checks++; if (host_wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", host_wr_ready); end
    n_checks++; if (icache_rd_ctrl_data !== 54'd0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", icache_rd_ctrl_data); end
    n_checks++; if (finish_flag !== 1'b1) begin n_errors++; $display("FAIL reset_finish: got %b expected 1", finish_flag); end
  endtask

  task automatic test_read_before_load();
    read_addr(10'd0);
    n_checks++; if (icache_rd_ctrl_data !== 54'd0 || finish_flag !== 1'b1) begin n_errors++; $display("FAIL empty_read: got %h/%b expected 0/1", icache_rd_ctrl_data, finish_flag); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (icache_rd_ctrl_data !== 54'd0 || finish_flag !== 1'b1) begin n_errors++; $display("FAIL empty_hold: got %h/%b expected 0/1", icache_rd_ctrl_data, finish_flag); end
  endtask

  task automatic test_basic_load();
    logic [53:0] exp_d [4];
    logic        exp_f [4];
    exp_d[0] = WA; exp_d[1] = WB; exp_d[2] = WC; exp_d[3] = 54'd0;
    exp_f[0] = 1'b0; exp_f[1] = 1'b0; exp_f[2] = 1'b0; exp_f[3] = 1'b1;
    write_word(WA, 1'b0);
    n_checks++; if (prog_len !== 11'd1 || prog_loaded !== 1'b0 || host_wr_ready !== 1'b1) begin n_errors++; $display("FAIL loading_state: got len=%0d loaded=%b ready=%b expected 1/0/1", prog_len, prog_loaded, host_wr_ready); end
    write_word(WB, 1'b0);
    write_word(WC, 1'b1);
    n_checks++; if (prog_loaded !== 1'b1 || prog_len !== 11'd3 || host_wr_ready !== 1'b0) begin n_errors++; $display("FAIL loaded_state: got loaded=%b len=%0d ready=%b expected 1/3/0", prog_loaded, prog_len, host_wr_ready); end
    for (int i = 0; i < 4; i++) begin
      read_addr(10'(i));
      n_checks++; if (icache_rd_ctrl_data !== exp_d[i] || finish_flag !== exp_f[i]) begin n_errors++; $display("FAIL basic_read[%0d]: got %h/%b expected %h/%b", i, icache_rd_ctrl_data, finish_flag, exp_d[i], exp_f[i]); end
    end
  endtask

  task automatic test_hold();
    read_addr(10'd1);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (icache_rd_ctrl_data !== WB || finish_flag !== 1'b0) begin n_errors++; $display("FAIL read_hold: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, WB); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    write_word(WX, 1'b0);
    @(negedge clk);
    host_wr_valid       = 1'b1;
    host_wr_data        = WY;
    host_wr_last        = 1'b1;
    icache_rd_ctrl_en   = 1'b1;
    icache_rd_ctrl_addr = 10'd0;
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
    n_checks++; if (finish_flag !== 1'b1 || icache_rd_ctrl_data !== 54'd0) begin n_errors++; $display("FAIL same_cycle_read: got %h/%b expected 0/1", icache_rd_ctrl_data, finish_flag); end
    @(posedge clk);
    #1;
    icache_rd_ctrl_en = 1'b0;
    n_checks++; if (finish_flag !== 1'b0 || icache_rd_ctrl_data !== WX) begin n_errors++; $display("FAIL next_cycle_read: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, WX); end
  endtask

  task automatic test_clear_priority();
    pulse_clear();
    write_word(WA, 1'b0);
    write_word(WB, 1'b0);
    write_word(WC, 1'b1);
    n_checks++; if (prog_len !== 11'd3 || prog_loaded !== 1'b1) begin n_errors++; $display("FAIL clr_setup: got len=%0d loaded=%b expected 3/1", prog_len, prog_loaded); end
    @(negedge clk);
    host_clear    = 1'b1;
    host_wr_valid = 1'b1;
    host_wr_data  = WY;
    host_wr_last  = 1'b1;
    @(posedge clk);
    #1;
    host_clear    = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
    n_checks++; if (prog_len !== 11'd0 || prog_loaded !== 1'b0 || host_wr_ready !== 1'b1 || load_ovf !== 1'b0) begin n_errors++; $display("FAIL clr_state: got len=%0d loaded=%b ready=%b ovf=%b expected 0/0/1/0", prog_len, prog_loaded, host_wr_ready, load_ovf); end
    read_addr(10'd0);
    n_checks++; if (finish_flag !== 1'b1 || icache_rd_ctrl_data !== 54'd0) begin n_errors++; $display("FAIL clr_read: got %h/%b expected 0/1", icache_rd_ctrl_data, finish_flag); end
  endtask

  task automatic test_reset_midload();
    write_word(WK, 1'b1);
    read_addr(10'd0);
    n_checks++; if (icache_rd_ctrl_data !== WK || finish_flag !== 1'b0) begin n_errors++; $display("FAIL rst_setup_read: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, WK); end
    pulse_clear();
    write_word(WA, 1'b0);
    write_word(WB, 1'b0);
    n_checks++; if (prog_len !== 11'd2) begin n_errors++; $display("FAIL rst_pre_len: got %0d expected 2", prog_len); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (prog_len !== 11'd0 || finish_flag !== 1'b1 || icache_rd_ctrl_data !== 54'd0 || host_wr_ready !== 1'b1) begin n_errors++; $display("FAIL async_reset: got len=%0d fin=%b data=%h ready=%b expected 0/1/0/1", prog_len, finish_flag, icache_rd_ctrl_data, host_wr_ready); end
    @(negedge clk);
    rst_n         = 1'b1;
    host_wr_valid = 1'b1;
    host_wr_data  = WM0;
    host_wr_last  = 1'b0;
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    n_checks++; if (prog_len !== 11'd1) begin n_errors++; $display("FAIL first_write_after_reset: got len=%0d expected 1", prog_len); end
    write_word(WM1, 1'b1);
    n_checks++; if (prog_len !== 11'd2 || prog_loaded !== 1'b1) begin n_errors++; $display("FAIL reload: got len=%0d loaded=%b expected 2/1", prog_len, prog_loaded); end
    read_addr(10'd0);
    n_checks++; if (icache_rd_ctrl_data !== WM0 || finish_flag !== 1'b0) begin n_errors++; $display("FAIL reload_read0: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, WM0); end
    read_addr(10'd1);
    n_checks++; if (icache_rd_ctrl_data !== WM1 || finish_flag !== 1'b0) begin n_errors++; $display("FAIL reload_read1: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, WM1); end
  endtask

  task automatic test_overflow();
    pulse_clear();
    for (int i = 0; i < 1023; i++) begin
      write_word(ovf_word(i), 1'b0);
    end
    n_checks++; if (prog_len !== 11'd1023 || prog_loaded !== 1'b0 || load_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_pre: got len=%0d loaded=%b ovf=%b expected 1023/0/0", prog_len, prog_loaded, load_ovf); end
    write_word(ovf_word(1023), 1'b0);
    n_checks++; if (prog_len !== 11'd1024 || prog_loaded !== 1'b1 || load_ovf !== 1'b1 || host_wr_ready !== 1'b0) begin n_errors++; $display("FAIL ovf_full: got len=%0d loaded=%b ovf=%b ready=%b expected 1024/1/1/0", prog_len, prog_loaded, load_ovf, host_wr_ready); end
    write_word(54'h3_FFFF_FFFF_FFFF, 1'b1);
    n_checks++; if (prog_len !== 11'd1024 || load_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_extra_write: got len=%0d ovf=%b expected 1024/1", prog_len, load_ovf); end
    read_addr(10'd1023);
    n_checks++; if (icache_rd_ctrl_data !== ovf_word(1023) || finish_flag !== 1'b0) begin n_errors++; $display("FAIL ovf_read1023: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, ovf_word(1023)); end
    read_addr(10'd0);
    n_checks++; if (icache_rd_ctrl_data !== ovf_word(0) || finish_flag !== 1'b0) begin n_errors++; $display("FAIL ovf_read0: got %h/%b expected %h/0", icache_rd_ctrl_data, finish_flag, ovf_word(0)); end
    pulse_clear();
    n_checks++; if (load_ovf !== 1'b0 || prog_len !== 11'd0) begin n_errors++; $display("FAIL ovf_clear: got ovf=%b len=%0d expected 0/0", load_ovf, prog_len); end
  endtask

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    rst_n               = 1'b0;
    host_clear          = 1'b0;
    host_wr_valid       = 1'b0;
    host_wr_data        = '0;
    host_wr_last        = 1'b0;
    icache_rd_ctrl_en   = 1'b0;
    icache_rd_ctrl_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_read_before_load();
    test_basic_load();
    test_hold();
    test_back_to_back();
    test_clear_priority();
    test_reset_midload();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
